// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word-aligned requests to instruction memory and
// presents fetched words to IF/ID. It parks a word under stall and drains abandoned requests.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_addr_o,
  output logic [31:0] instr_o,
  output logic        valid_o,
  output logic        flush_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_buf_data;
  logic [31:0] r_buf_addr;
  logic [31:0] r_drain_addr;
  logic [31:0] r_instr;
  logic [31:0] r_instr_addr;
  logic        r_valid;

  logic [31:0] w_target;
  logic [31:0] w_pc_next;

  assign w_target  = branch_target_i & 32'hFFFF_FFFC;
  assign w_pc_next = r_pc + 32'd4;

  // Handshake: a request is live while imem_req_o=1 and completes on the cycle
  // imem_ready_i=1; imem_addr_o is held steady until then.
  assign imem_req_o   = (r_state != HOLD);
  assign imem_addr_o  = (r_state == DRAIN) ? r_drain_addr : r_pc;
  assign flush_o      = branch_i;
  assign instr_o      = r_instr;
  assign instr_addr_o = r_instr_addr;
  assign valid_o      = r_valid;
  assign dbg_state_o  = r_state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_buf_data   <= 32'd0;
      r_buf_addr   <= 32'd0;
      r_drain_addr <= 32'd0;
      r_instr      <= 32'd0;
      r_instr_addr <= 32'd0;
      r_valid      <= 1'b0;
    end else if (branch_i) begin
      r_pc         <= w_target;
      r_instr      <= 32'd0;
      r_instr_addr <= 32'd0;
      r_valid      <= 1'b0;
      r_buf_data   <= 32'd0;
      r_buf_addr   <= 32'd0;
      case (r_state)
        FETCH: begin
          // An unfinished request must still be absorbed before redirecting.
          if (!imem_ready_i) begin
            r_state      <= DRAIN;
            r_drain_addr <= r_pc;
          end
        end
        HOLD:    r_state <= FETCH;
        DRAIN:   r_state <= DRAIN;
        default: r_state <= FETCH;
      endcase
    end else begin
      case (r_state)
        FETCH: begin
          if (imem_ready_i) begin
            r_pc <= w_pc_next;
            if (stall_i) begin
              r_buf_data <= imem_data_i;
              r_buf_addr <= r_pc;
              r_state    <= HOLD;
            end else begin
              r_instr      <= imem_data_i;
              r_instr_addr <= r_pc;
              r_valid      <= 1'b1;
            end
          end else if (!stall_i) begin
            r_instr      <= 32'd0;
            r_instr_addr <= 32'd0;
            r_valid      <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            r_instr      <= r_buf_data;
            r_instr_addr <= r_buf_addr;
            r_valid      <= 1'b1;
            r_state      <= FETCH;
          end
        end
        DRAIN: begin
          if (imem_ready_i) r_state <= FETCH;
        end
        default: r_state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a transaction-level model predicts every output each
// cycle, with literal checks on key points of the fetch stream.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_i, stall_i, branch_i, imem_ready_i;
  logic [31:0] branch_target_i, imem_data_i;
  logic        imem_req_o, valid_o, flush_o;
  logic [31:0] imem_addr_o, instr_addr_o, instr_o;
  logic [1:0]  dbg_state_o;

  logic        w_req, w_valid, w_flush;
  logic [31:0] w_addr, w_iaddr, w_instr;
  logic [1:0]  w_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .branch_i(branch_i),
    .branch_target_i(branch_target_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_data_i(imem_data_i), .instr_addr_o(instr_addr_o),
    .instr_o(instr_o), .valid_o(valid_o), .flush_o(flush_o), .dbg_state_o(dbg_state_o)
  );

  // Second instance: reset vector at the top of the address space, memory always ready.
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk_i(clk), .rst_i(rst_i), .stall_i(1'b0), .branch_i(1'b0),
    .branch_target_i(32'd0), .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_ready_i(1'b1), .imem_data_i(32'h0000_0013), .instr_addr_o(w_iaddr),
    .instr_o(w_instr), .valid_o(w_valid), .flush_o(w_flush), .dbg_state_o(w_dbg)
  );

  // Model: the PC to fetch, at most one parked word, and an optional abandoned request.
  logic [31:0] held_addr_q[$];
  logic [31:0] held_data_q[$];
  logic [31:0] m_pc, m_ab_addr, m_instr, m_iaddr;
  logic        m_abandon, m_valid, m_known;

  function automatic logic m_req();
    return held_addr_q.size() == 0;
  endfunction

  function automatic logic [31:0] m_addr();
    return m_abandon ? m_ab_addr : m_pc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic rst, input logic stall, input logic br,
                              input logic [31:0] tgt, input logic rdy, input logic [31:0] d);
    if (rst) begin
      m_pc = 32'h0; m_abandon = 1'b0; m_known = 1'b1;
      held_addr_q.delete(); held_data_q.delete();
      m_instr = 0; m_iaddr = 0; m_valid = 0;
    end else if (br) begin
      if (held_addr_q.size() == 0 && !m_abandon && !rdy) begin
        m_abandon = 1'b1; m_ab_addr = m_pc;
      end
      held_addr_q.delete(); held_data_q.delete();
      m_pc = {tgt[31:2], 2'b00};
      m_instr = 0; m_iaddr = 0; m_valid = 0;
    end else if (m_abandon) begin
      if (rdy) m_abandon = 1'b0;
    end else if (held_addr_q.size() != 0) begin
      if (!stall) begin
        m_iaddr = held_addr_q.pop_front();
        m_instr = held_data_q.pop_front();
        m_valid = 1'b1;
      end
    end else if (rdy) begin
      if (stall) begin
        held_addr_q.push_back(m_pc); held_data_q.push_back(d);
      end else begin
        m_iaddr = m_pc; m_instr = d; m_valid = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end else if (!stall) begin
      m_instr = 0; m_iaddr = 0; m_valid = 0;
    end
  endtask

  // One clock: drive after the falling edge, compare, then advance the model on the rising edge.
  task automatic cyc(input logic rst, input logic stall, input logic br,
                     input logic [31:0] tgt, input logic rdy_pat);
    logic        rdy;
    logic [31:0] d;
    rdy = rdy_pat && m_req();
    d   = m_addr() + 32'd100;
    rst_i = rst; stall_i = stall; branch_i = br; branch_target_i = tgt;
    imem_ready_i = rdy; imem_data_i = rdy ? d : 32'hDEAD_BEEF;
    #1;
    chk("flush_o", {31'd0, flush_o}, {31'd0, br});
    if (m_known) begin
      chk("valid_o", {31'd0, valid_o}, {31'd0, m_valid});
      chk("instr_o", instr_o, m_instr);
      chk("instr_addr_o", instr_addr_o, m_iaddr);
      chk("imem_req_o", {31'd0, imem_req_o}, {31'd0, m_req()});
      if (m_req()) chk("imem_addr_o", imem_addr_o, m_addr());
    end
    @(posedge clk);
    model_update(rst, stall, br, tgt, rdy, d);
    @(negedge clk);
  endtask

  initial begin
    m_known = 1'b0; m_abandon = 1'b0; m_pc = 0; m_ab_addr = 0;
    m_instr = 0; m_iaddr = 0; m_valid = 0;
    rst_i = 1'b1; stall_i = 1'b0; branch_i = 1'b0; branch_target_i = 0;
    imem_ready_i = 1'b0; imem_data_i = 0;
    @(negedge clk);

    // Reset with a branch and a response present: both are overridden.
    cyc(1, 0, 1, 32'h40, 1);
    cyc(1, 0, 0, 0, 0);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_req_addr", imem_addr_o, 32'h0);
    chk("wrap_first_addr", w_addr, 32'hFFFF_FFFC);

    // Zero-wait stream.
    cyc(0, 0, 0, 0, 1);
    chk("wrap_next_addr", w_addr, 32'h0);
    chk("wrap_iaddr", w_iaddr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("stream_iaddr", instr_addr_o, 32'h8);
    chk("stream_instr", instr_o, 32'd108);
    chk("stream_valid", {31'd0, valid_o}, 32'd1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);

    // Two-wait memory.
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, (i % 3) == 2);
    cyc(0, 0, 0, 0, 0);
    chk("bubble_instr", instr_o, 32'd0);

    // Stall for three cycles arriving with the response for address 8.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    chk("hold_iaddr", instr_addr_o, 32'h4);
    chk("hold_no_req", {31'd0, imem_req_o}, 32'd0);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("release_iaddr", instr_addr_o, 32'h8);
    cyc(0, 0, 0, 0, 1);
    chk("after_iaddr", instr_addr_o, 32'hC);

    // Branch while request 0x10 is pending, and a stall on an unfinished request.
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 32'h200, 0);
    chk("drain_addr", imem_addr_o, 32'h10);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("branch_iaddr", instr_addr_o, 32'h200);

    // Branch together with stall in HOLD; unaligned target.
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 1, 32'h303, 0);
    chk("hold_br_addr", imem_addr_o, 32'h300);
    cyc(0, 0, 0, 0, 1);
    chk("hold_br_iaddr", instr_addr_o, 32'h300);

    // Branch in FETCH with data ready, then repeated branches in DRAIN.
    cyc(0, 0, 1, 32'h1000, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h2000, 0);
    cyc(0, 1, 1, 32'h3000, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("drain_newest_iaddr", instr_addr_o, 32'h3000);

    // PC wrap through a redirect to the last word.
    cyc(0, 0, 1, 32'hFFFF_FFFF, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("wrap_iaddr_zero", instr_addr_o, 32'h0);

    // Reset in the middle of a drain.
    cyc(0, 0, 1, 32'h500, 0);
    cyc(1, 0, 0, 0, 1);
    chk("rst_drain_addr", imem_addr_o, 32'h0);
    chk("rst_drain_valid", {31'd0, valid_o}, 32'd0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
